// File: rtl/proc_out_fifo_pkg.sv
//==============================================================================
// Module      : proc_out_fifo_pkg
// Description : Shared helpers for the processor output FIFO. The package
//               provides a width function that never returns less than one
//               bit, so that a single-address port still gets a real address
//               bus.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package proc_out_fifo_pkg;

   // Returns ceil(log2(n)), with a minimum of 1 bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/proc_out_fifo_ram.sv
//==============================================================================
// Module      : fifo_ram
// Description : Simple dual-port RAM with a synchronous write port and a
//               synchronous, registered read port. When the read and write
//               addresses match in the same cycle, the read returns the data
//               being written (write-first).
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset (read register only)
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address, sampled every cycle
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_ram
   import proc_out_fifo_pkg::*;
#(
   parameter  int NADDRE = 8,
   parameter  int NBDATA = 17,
   localparam int NBA    = addr_width(NADDRE)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [NBA-1:0]    i_waddr,
   input  logic [NBDATA-1:0] i_wdata,
   input  logic [NBA-1:0]    i_raddr,
   output logic [NBDATA-1:0] o_rdata
);

   logic [NBDATA-1:0] r_mem [NADDRE];
   logic [NBDATA-1:0] r_rdata;

   // Storage is not reset; its contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Write-first forwarding lets an entry written into an empty FIFO be
   // presented on the very next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/proc_out_fifo.sv
//==============================================================================
// Module      : proc_out_fifo
// Description : Output-port buffer placed after the processor output bus.
//               Every out_en write is captured as an {address, data} entry in
//               a circular FIFO. Entries drain to a consumer over valid/ready
//               in strict write order. All outputs are registered
//               (show-ahead).
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               out_en   - processor output strobe, one write per high cycle
//               addr_out - processor output address, sampled with out_en
//               io_out   - processor output data, sampled with out_en
//               m_valid  - head entry available
//               m_ready  - consumer accepts the head when m_valid && m_ready
//               m_addr   - head entry address
//               m_data   - head entry data
//               full     - occupancy equals FDEPTH
//               count    - occupancy, 0..FDEPTH
//               ovf      - sticky: a write was dropped while full
//               ovf_clr  - synchronous clear of ovf (a new drop wins)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module proc_out_fifo
   import proc_out_fifo_pkg::*;
#(
   parameter  int NUBITS = 16,
   parameter  int NUIOOU = 2,
   parameter  int FDEPTH = 8,
   localparam int NBADDR = addr_width(NUIOOU),
   localparam int FDEPW  = $clog2(FDEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              out_en,
   input  logic [NBADDR-1:0] addr_out,
   input  logic [NUBITS-1:0] io_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [NBADDR-1:0] m_addr,
   output logic [NUBITS-1:0] m_data,
   output logic              full,
   output logic [FDEPW:0]    count,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int             NBENTRY = NBADDR + NUBITS;
   localparam logic [FDEPW:0] C_FULL  = (FDEPW+1)'(FDEPTH);

   logic [FDEPW-1:0]   r_wptr;
   logic [FDEPW-1:0]   r_rptr;
   logic [FDEPW:0]     r_count;
   logic               r_valid;
   logic               r_full;
   logic               r_ovf;

   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [FDEPW:0]     w_count_nxt;
   logic [FDEPW-1:0]   w_raddr;
   logic [NBENTRY-1:0] w_rdata;

   assign w_pop  = r_valid && m_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_push = out_en && (!r_full || w_pop);
   assign w_drop = out_en && !w_push;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Look ahead to the next head so the registered RAM output already holds
   // it on the cycle after a pop.
   assign w_raddr = r_rptr + FDEPW'(w_pop);

   fifo_ram #(
      .NADDRE (FDEPTH),
      .NBDATA (NBENTRY)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_push),
      .i_waddr (r_wptr),
      .i_wdata ({addr_out, io_out}),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         r_full  <= (w_count_nxt == C_FULL);
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign m_valid          = r_valid;
   assign {m_addr, m_data} = w_rdata;
   assign full             = r_full;
   assign count            = r_count;
   assign ovf              = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_proc_out_fifo.sv
//==============================================================================
// Module      : tb_proc_out_fifo
// Description : Self-checking bench for proc_out_fifo. A queue-based model
//               tracks the expected FIFO contents and overflow flag. Directed
//               scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_proc_out_fifo;

   localparam int NUBITS = 16;
   localparam int NBADDR = 1;
   localparam int FDEPTH = 8;

   logic              clk;
   logic              rst;
   logic              out_en;
   logic [NBADDR-1:0] addr_out;
   logic [NUBITS-1:0] io_out;
   logic              m_valid;
   logic              m_ready;
   logic [NBADDR-1:0] m_addr;
   logic [NUBITS-1:0] m_data;
   logic              full;
   logic [3:0]        count;
   logic              ovf;
   logic              ovf_clr;

   proc_out_fifo #(
      .NUBITS (NUBITS),
      .NUIOOU (2),
      .FDEPTH (FDEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .out_en   (out_en),
      .addr_out (addr_out),
      .io_out   (io_out),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_addr   (m_addr),
      .m_data   (m_data),
      .full     (full),
      .count    (count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of {addr, data} entries plus the sticky flag.
   logic [NBADDR+NUBITS-1:0] mq [$];
   logic                     m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(m_valid), 32'(mq.size() != 0));
      chk({tag, ".count"}, 32'(count),   32'(mq.size()));
      chk({tag, ".full"},  32'(full),    32'(mq.size() == FDEPTH));
      chk({tag, ".ovf"},   32'(ovf),     32'(m_ovf));
      if (mq.size() != 0) begin
         chk({tag, ".addr"}, 32'(m_addr), 32'(mq[0][NUBITS]));
         chk({tag, ".data"}, 32'(m_data), 32'(mq[0][NUBITS-1:0]));
      end
   endtask

   // One clock cycle: drive inputs, update the model at the edge, then check.
   task automatic step(input logic oe, input logic [NBADDR-1:0] a,
                       input logic [NUBITS-1:0] d, input logic rdy,
                       input logic clr, input string tag);
      bit pop, push, drop;
      out_en   = oe;
      addr_out = a;
      io_out   = d;
      m_ready  = rdy;
      ovf_clr  = clr;
      pop  = (mq.size() != 0) && rdy;
      push = oe && ((mq.size() < FDEPTH) || pop);
      drop = oe && !push;
      @(posedge clk);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({a, d});
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, '0, '0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      rst      = 1'b0;
      out_en   = 1'b0;
      addr_out = '0;
      io_out   = '0;
      m_ready  = 1'b0;
      ovf_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", 32'(m_valid), 32'd0);
      chk("rst.count", 32'(count),   32'd0);
      chk("rst.full",  32'(full),    32'd0);
      chk("rst.ovf",   32'(ovf),     32'd0);
      chk("rst.addr",  32'(m_addr),  32'd0);
      chk("rst.data",  32'(m_data),  32'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Single write, hold, then accept.
      step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, "single_wr");
      chk("single.data", 32'(m_data), 32'h1234);
      repeat (5) idle("single_hold");
      chk("single.hold_data", 32'(m_data), 32'h1234);
      step(1'b0, '0, '0, 1'b1, 1'b0, "single_pop");
      chk("single.empty", 32'(m_valid), 32'd0);

      // Burst fill, one dropped write, full drain.
      for (int i = 0; i < 8; i++) step(1'b1, 1'(i), 16'(i), 1'b0, 1'b0, "burst_fill");
      chk("burst.full", 32'(full), 32'd1);
      step(1'b1, 1'b0, 16'd99, 1'b0, 1'b0, "burst_drop");
      chk("burst.ovf", 32'(ovf), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0, "burst_drain");
      chk("burst.empty", 32'(count), 32'd0);

      // Full with simultaneous push and pop.
      step(1'b0, '0, '0, 1'b0, 1'b1, "clr_ovf");
      for (int i = 0; i < 8; i++) step(1'b1, '0, 16'(i), 1'b0, 1'b0, "pp_fill");
      step(1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, "pp_both");
      chk("pp.count", 32'(count), 32'd8);
      chk("pp.ovf",   32'(ovf),   32'd0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0, "pp_drain");

      // Streaming: simultaneous write and accept every cycle.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'($urandom), 16'(16'h100 + i), 1'b1, 1'b0, "stream");
         chk("stream.cnt_le1", 32'(count <= 4'd1), 32'd1);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0, "stream_end");

      // Asynchronous reset with entries queued and ovf set.
      for (int i = 0; i < 9; i++) step(1'b1, '0, 16'(16'h200 + i), 1'b0, 1'b0, "pre_rst");
      repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, "pre_rst_drain");
      #2 rst = 1'b0;
      #1;
      mq.delete();
      m_ovf = 1'b0;
      chk("arst.valid", 32'(m_valid), 32'd0);
      chk("arst.count", 32'(count),   32'd0);
      chk("arst.full",  32'(full),    32'd0);
      chk("arst.ovf",   32'(ovf),     32'd0);
      #1 rst = 1'b1;
      step(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, "post_rst_wr");
      chk("arst.first", 32'(m_data), 32'h5A5A);
      step(1'b0, '0, '0, 1'b1, 1'b0, "post_rst_pop");

      // Overflow clear race: a drop wins over a simultaneous clear.
      for (int i = 0; i < 9; i++) step(1'b1, '0, 16'(16'h300 + i), 1'b0, 1'b0, "race_fill");
      step(1'b1, '0, 16'hDEAD, 1'b0, 1'b1, "race_drop_clr");
      chk("race.ovf_set", 32'(ovf), 32'd1);
      step(1'b0, '0, '0, 1'b0, 1'b1, "race_clr");
      chk("race.ovf_clr", 32'(ovf), 32'd0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0, "race_drain");

      // Randomized traffic with varying write and accept pressure.
      for (int i = 0; i < 400; i++) begin
         logic oe, rdy, clr;
         if (i < 200) begin
            oe  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) == 0);
         end else begin
            oe  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
         end
         clr = ($urandom_range(0, 15) == 0);
         step(oe, 1'($urandom), 16'($urandom), rdy, clr, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/proc_out_fifo.md
Name: proc_out_fifo

Overview:
- Output-port buffer placed directly downstream of the fixed-point processor's output bus (io_out / addr_out / out_en).
- Captures every processor output write as an {address, data} pair into a circular FIFO.
- Drains entries to a peripheral consumer over a valid/ready handshake, so a slow sink does not lose back-to-back OUT instructions.
- Reports occupancy, full and a sticky overflow flag.

Parameters:
- NUBITS, 16, processor word width; must equal the processor's NUBITS.
- NUIOOU, 2, number of processor output addresses; address width NBADDR = $clog2(NUIOOU), minimum 1.
- FDEPTH, 8, FIFO depth in entries; power of two, at least 2.
- FDEPW, $clog2(FDEPTH), pointer width (internal, do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- out_en  in  1  processor output strobe; one write per high cycle.
- addr_out  in  NBADDR  processor output port address, sampled with out_en.
- io_out  in  NUBITS  processor output data, sampled with out_en.
- m_valid  out  1  head entry available.
- m_ready  in  1  consumer accepts the head entry when m_valid && m_ready.
- m_addr  out  NBADDR  head entry address.
- m_data  out  NUBITS  head entry data.
- full  out  1  count == FDEPTH.
- count  out  FDEPW+1  current occupancy, 0..FDEPTH.
- ovf  out  1  sticky: a write was dropped.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst low, asynchronous): write/read pointers = 0, count = 0, m_valid = 0, m_addr = 0, m_data = 0, full = 0, ovf = 0. Storage contents are don't-care. A reset mid-drain discards all entries immediately.
- push = out_en && (!full || pop); pop = m_valid && m_ready.
- Push writes {addr_out, io_out} at wptr; wptr increments modulo FDEPTH (natural wrap).
- Pop increments rptr modulo FDEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs are registered (show-ahead):
  - m_valid, m_addr and m_data reflect the head entry one cycle after the state change.
  - Write-to-m_valid latency from empty is 1 cycle: out_en at edge N gives m_valid high after edge N+1 with that data.
  - No combinational path from out_en or io_out to the outputs.
- m_addr and m_data hold stable while m_valid && !m_ready.
- Empty and out_en and m_ready in the same cycle: no bypass; the entry is written and presented the next cycle.
- Full and out_en with pop: the write is accepted; count stays FDEPTH.
- Full and out_en without pop: the write is dropped, state is unchanged, and ovf is set on the next edge.
- ovf stays high until ovf_clr or reset. If ovf_clr and a new drop occur in the same cycle, the set wins.
- m_valid falls on the cycle after the last entry pops, unless a push occurred in the same cycle.
- full and count are registered and consistent with the pointers every cycle.
- Entries are emitted in strict write order. Address is not used for routing (downstream decoding is the consumer's job).

Decomposition:
- No shared package is required. Entry width NBADDR+NUBITS is a localparam.
- One natural sub-module: fifo_ram, a simple dual-port RAM.
  - Parameters: NADDRE = FDEPTH, NBDATA = NBADDR+NUBITS.
  - Synchronous write, synchronous read, with the same port style as the existing data memory.
- Pointer, count, flag and output-register logic stay in proc_out_fifo.
- Read-address lookahead: the RAM read address is rptr + pop, so the next head appears with 1-cycle latency.

Test Plan:
- Single write: out_en=1 one cycle with addr_out=1, io_out=16'h1234, m_ready=0 -> one cycle later m_valid=1, m_addr=1, m_data=16'h1234, count=1; values held 5 cycles; raise m_ready -> m_valid=0 next cycle, count=0.
- Burst fill: 8 consecutive writes of data 0..7 with m_ready=0 -> full=1, count=8, ovf=0; 9th write (data 99) -> ovf=1, count=8; drain with m_ready=1 -> output sequence 0..7 only, 99 never appears.
- Full with simultaneous push/pop: fill 8, then out_en with data 16'hAAAA and m_ready=1 in the same cycle -> count stays 8, ovf=0; full drain yields 1..7 then 16'hAAAA.
- Streaming: out_en and m_ready held high 20 cycles with incrementing data -> output equals input delayed 1 cycle, count stays ≤1, no drops, pointers wrap correctly past FDEPTH.
- Async reset mid-operation: 5 entries queued, rst pulsed low between clock edges -> m_valid, count, ovf and full go to 0 immediately without a clock; the first write after release is output first.
- Overflow clear race: ovf=1, then assert ovf_clr in the same cycle as a dropped write -> ovf remains 1; assert ovf_clr alone -> ovf=0 next cycle.
